pipeline_control_unit: RTL
==========================

// Module: pipeline_control_unit
// PURPOSE
//  Consumer side of the hazard signals: turns the load-use stall request, the branch/jump
//  flush request, data-memory wait and halt into per-stage write enables and flushes.
//  Sits beside the 5-stage datapath and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB
//  pipeline registers. Also tracks memory-wait timeout and keeps saturating perf counters.
// PARAMETERS
//  CNT_W        32   width of each performance counter
//  MEM_TIMEOUT  64   consecutive memory-wait cycles before the error trap; 0 = disabled
// PORTS
//  clk            in   1      single clock, all state updates on rising edge
//  rst_n          in   1      synchronous reset, active-low
//  stall_req      in   1      load-use stall from hazard detection (ID vs EX)
//  flush_req      in   1      taken branch/jump resolved in MEM stage
//  mem_req        in   1      MEM stage is accessing data memory this cycle
//  mem_ready      in   1      data memory completes access this cycle
//  halt_req       in   1      ecall/ebreak has reached MEM/WB
//  pc_we          out  1      PC register write enable
//  if_id_we       out  1      IF/ID write enable
//  if_id_flush    out  1      IF/ID clear to NOP
//  id_ex_we       out  1      ID/EX write enable
//  id_ex_flush    out  1      ID/EX clear to NOP (bubble)
//  ex_mem_we      out  1      EX/MEM write enable
//  ex_mem_flush   out  1      EX/MEM clear to NOP
//  mem_wb_we      out  1      MEM/WB write enable
//  halted         out  1      core in HALTED state
//  timeout_err    out  1      sticky memory-wait timeout flag
//  stall_cnt      out  CNT_W  load-use stall cycles applied
//  flush_cnt      out  CNT_W  flush events applied
//  wait_cnt       out  CNT_W  cycles frozen on memory wait
// BEHAVIOUR
//  - States: RUN, MEM_WAIT, HALTED, ERROR. Control outputs are combinational from
//    state + inputs (same-cycle effect); state, counters and flags are registered.
//  - rst_n low at an edge: state<=RUN, counters<=0, timeout_err<=0, internal wait timer<=0.
//    While rst_n is low: all *_we=0, all *_flush=1, halted=0. Reset mid-wait/halt/error
//    returns to RUN at that edge.
//  - Default (RUN, no request): all *_we=1, all *_flush=0.
//  - Priority in RUN/MEM_WAIT, highest first:
//    1 FREEZE: mem_req && !mem_ready -> all *_we=0, no flushes; stall/flush/halt ignored
//      (EX/MEM held, so flush_req/halt_req persist and are honoured on release).
//    2 HALT: halt_req -> all *_we=0, no flushes; next state HALTED.
//    3 FLUSH: flush_req -> pc_we=1 (redirect), if_id_flush=id_ex_flush=ex_mem_flush=1,
//      mem_wb_we=1; stall_req ignored (the dependent instruction is killed); flush_cnt++.
//    4 STALL: stall_req -> pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=mem_wb_we=1;
//      stall_cnt++. A 1-cycle load-use gives exactly one bubble; held stall_req repeats.
//  - RUN -> MEM_WAIT on FREEZE; wait timer<=1, wait_cnt++.
//  - MEM_WAIT: while !mem_ready stay, timer++, wait_cnt++. mem_ready=1 -> release that cycle
//    (apply priorities 2-4 normally), next RUN, timer<=0. Timer reaching MEM_TIMEOUT with
//    mem_ready=0 -> ERROR, timeout_err<=1. MEM_TIMEOUT=0 never traps.
//  - HALTED / ERROR: all *_we=0, no flushes; inputs ignored; exit only via reset.
//    halted=1 only in HALTED.
//  - Counters saturate at 2^CNT_W-1, never wrap. Each counter increments at most once per cycle.
// TESTING
//  - Reset: hold rst_n=0 two cycles -> all *_we=0, *_flush=1, counters 0; release -> all *_we=1.
//  - Load-use: stall_req=1 one cycle -> pc_we=0, if_id_we=0, id_ex_flush=1 that cycle only; stall_cnt=1.
//  - Flush over stall: stall_req=1 and flush_req=1 together -> pc_we=1, three flushes=1; stall_cnt=0, flush_cnt=1.
//  - Mem wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 with flush_req=1 -> 3 frozen cycles,
//    wait_cnt=3, flush applied on the 4th cycle.
//  - Timeout: MEM_TIMEOUT=4, mem_ready stuck 0 -> ERROR after 4 wait cycles, timeout_err=1; rst_n clears it.
//  - Halt: halt_req=1 in RUN -> all *_we=0, halted=1 next cycle, stays until rst_n=0.

Source files
------------

// File: rtl/pipeline_control_unit_if.sv
// Handshake bundle between the hazard/datapath side and pipeline_control_unit.
//   Requests (master -> slave): stall_req, flush_req, mem_req, mem_ready, halt_req
//   Controls (slave -> master): pc_we, if_id_we/flush, id_ex_we/flush,
//                               ex_mem_we/flush, mem_wb_we, halted, timeout_err
//   Perf counters (slave -> master): stall_cnt, flush_cnt, wait_cnt (CNT_W bits each)
interface pipeline_control_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic             stall_req;
  logic             flush_req;
  logic             mem_req;
  logic             mem_ready;
  logic             halt_req;

  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_we;
  logic             id_ex_flush;
  logic             ex_mem_we;
  logic             ex_mem_flush;
  logic             mem_wb_we;
  logic             halted;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt;

  modport master (
    output stall_req, flush_req, mem_req, mem_ready, halt_req,
    input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
           ex_mem_we, ex_mem_flush, mem_wb_we, halted, timeout_err,
           stall_cnt, flush_cnt, wait_cnt
  );

  modport slave (
    input  stall_req, flush_req, mem_req, mem_ready, halt_req,
    output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
           ex_mem_we, ex_mem_flush, mem_wb_we, halted, timeout_err,
           stall_cnt, flush_cnt, wait_cnt
  );
endinterface

// File: rtl/pipeline_control_unit.sv
// Pipeline control for a 5-stage core: converts stall/flush/memory-wait/halt requests
// into per-stage write enables and flushes, traps on excessive memory wait and keeps
// saturating performance counters.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset (controls forced to we=0/flush=1 while low)
//   ctrl   : pipeline_control_unit_if.slave (requests in, controls/counters out)
module pipeline_control_unit #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input logic                    clk,
  input logic                    rst_n,
  pipeline_control_unit_if.slave ctrl
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED, ERROR} state_t;

  // Timer only needs to count up to MEM_TIMEOUT; it is idle when the trap is disabled.
  localparam int unsigned TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t          state, stateNext;
  logic [TW-1:0]   waitTimer, waitTimerNext, timerInc;
  logic [CNT_W-1:0] stallCnt, flushCnt, waitCnt;
  logic            timeoutErr;
  logic            incStall, incFlush, incWait, setErr;
  logic            freeze;

  logic pcWe, ifIdWe, ifIdFlush, idExWe, idExFlush, exMemWe, exMemFlush, memWbWe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      waitTimer  <= '0;
      stallCnt   <= '0;
      flushCnt   <= '0;
      waitCnt    <= '0;
      timeoutErr <= 1'b0;
    end else begin
      state     <= stateNext;
      waitTimer <= waitTimerNext;
      if (incStall && stallCnt != CNT_MAX) stallCnt <= stallCnt + 1'b1;
      if (incFlush && flushCnt != CNT_MAX) flushCnt <= flushCnt + 1'b1;
      if (incWait  && waitCnt  != CNT_MAX) waitCnt  <= waitCnt + 1'b1;
      if (setErr) timeoutErr <= 1'b1;
    end
  end

  always_comb begin
    stateNext     = state;
    waitTimerNext = waitTimer;
    incStall      = 1'b0;
    incFlush      = 1'b0;
    incWait       = 1'b0;
    setErr        = 1'b0;
    pcWe          = 1'b1;
    ifIdWe        = 1'b1;
    ifIdFlush     = 1'b0;
    idExWe        = 1'b1;
    idExFlush     = 1'b0;
    exMemWe       = 1'b1;
    exMemFlush    = 1'b0;
    memWbWe       = 1'b1;
    timerInc      = waitTimer + 1'b1;
    // Once waiting, only mem_ready ends the freeze; in RUN a request is needed to start it.
    freeze        = (state == MEM_WAIT) ? !ctrl.mem_ready : (ctrl.mem_req && !ctrl.mem_ready);

    case (state)
      RUN, MEM_WAIT: begin
        if (freeze) begin
          {pcWe, ifIdWe, idExWe, exMemWe, memWbWe} = '0;
          incWait = 1'b1;
          // waitTimer is 0 in RUN, so timerInc is the count of frozen cycles including this one.
          if (MEM_TIMEOUT != 0 && 32'(timerInc) >= MEM_TIMEOUT) begin
            stateNext     = ERROR;
            setErr        = 1'b1;
            waitTimerNext = '0;
          end else begin
            stateNext = MEM_WAIT;
            if (MEM_TIMEOUT != 0) waitTimerNext = timerInc;
          end
        end else begin
          stateNext     = RUN;
          waitTimerNext = '0;
          if (ctrl.halt_req) begin
            {pcWe, ifIdWe, idExWe, exMemWe, memWbWe} = '0;
            stateNext = HALTED;
          end else if (ctrl.flush_req) begin
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
            exMemFlush = 1'b1;
            incFlush   = 1'b1;
          end else if (ctrl.stall_req) begin
            pcWe      = 1'b0;
            ifIdWe    = 1'b0;
            idExFlush = 1'b1;
            incStall  = 1'b1;
          end
        end
      end
      default: begin
        {pcWe, ifIdWe, idExWe, exMemWe, memWbWe} = '0;
      end
    endcase

    if (!rst_n) begin
      {pcWe, ifIdWe, idExWe, exMemWe, memWbWe} = '0;
      {ifIdFlush, idExFlush, exMemFlush}       = '1;
    end
  end

  assign ctrl.pc_we        = pcWe;
  assign ctrl.if_id_we     = ifIdWe;
  assign ctrl.if_id_flush  = ifIdFlush;
  assign ctrl.id_ex_we     = idExWe;
  assign ctrl.id_ex_flush  = idExFlush;
  assign ctrl.ex_mem_we    = exMemWe;
  assign ctrl.ex_mem_flush = exMemFlush;
  assign ctrl.mem_wb_we    = memWbWe;
  assign ctrl.halted       = rst_n && (state == HALTED);
  assign ctrl.timeout_err  = timeoutErr;
  assign ctrl.stall_cnt    = stallCnt;
  assign ctrl.flush_cnt    = flushCnt;
  assign ctrl.wait_cnt     = waitCnt;

endmodule
